pwm_arbitro: RTL and testbench

Duty-cycle controller and arbiter for a single R-bit PWM channel. Owns the PWM period counter and the active duty register, and shares duty updates among NREQ requesters (sine sequencer, switch input, serial command path) by round-robin. Each granted value goes into a shadow register and becomes active only at a period boundary, so no PWM period is ever truncated or glitched.

---
 rtl/pwm_arbitro_pkg.sv | 10 +
 rtl/pwm_arbitro_if.sv | 18 +
 rtl/pwm_arbitro_rr.sv | 27 ++
 rtl/pwm_arbitro.sv | 54 +++++
 tb/tb_pwm_arbitro.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_arbitro_pkg.sv
// pwm_pkg: shared state encoding, default resolution and width helper for the PWM duty arbiter.
package pwm_pkg;
    typedef enum logic {IDLE, PEND} state_t;
    localparam int R_DEF = 6;
    function automatic int lg2(input int n);
        for (int w = 1; w < 32; w++)
            if ((1 << w) >= n) return w;
        return 32;
    endfunction
endpackage

// File: rtl/pwm_arbitro_if.sv
// pwm_arbitro_if: requester and PWM status bundle between the duty controller and its clients.
interface pwm_arbitro_if
    import pwm_pkg::*;
#(
    parameter int R    = R_DEF,
    parameter int NREQ = 3
);
    logic            en;
    logic [NREQ-1:0] req;
    logic [NREQ*R-1:0] duty_in;
    logic [NREQ-1:0] ack;
    logic [R-1:0]    duty_act;
    logic            period_end;
    logic            busy;
    logic            pwm_out;
    modport master (output en, req, duty_in, input ack, duty_act, period_end, busy, pwm_out);
    modport slave (input en, req, duty_in, output ack, duty_act, period_end, busy, pwm_out);
endinterface

// File: rtl/pwm_arbitro_rr.sv
// arbitro_rr: combinational round-robin pick, searching upward from ptr+1 with wrap.
module arbitro_rr #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] win,
    output logic         any
);
    logic [W-1:0] idx;
    // Walk the offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        gnt = '0;
        win = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                win = idx;
                gnt = N'(1) << idx;
            end
        end
    end
    assign any = |req;
endmodule

// File: rtl/pwm_arbitro.sv
// pwm_arbitro: PWM period counter and duty register; round-robin duty updates applied only at period boundaries.
module pwm_arbitro
    import pwm_pkg::*;
#(
    parameter int R        = R_DEF,
    parameter int NREQ     = 3,
    parameter int DUTY_RST = 2 ** (R - 1)
) (
    input logic         clk,
    input logic         rst_n,
    pwm_arbitro_if.slave bus
);
    localparam int LW = lg2(NREQ);
    logic [R-1:0]    q;
    logic [R-1:0]    shadow;
    logic [LW-1:0]   last_grant;
    logic [LW-1:0]   win;
    logic [NREQ-1:0] gnt;
    logic            any;
    state_t          state;
    arbitro_rr #(.N(NREQ), .W(LW)) u_rr (
        .req(bus.req),
        .ptr(last_grant),
        .gnt(gnt),
        .win(win),
        .any(any)
    );
    assign bus.period_end = bus.en && (q == '1);
    assign bus.busy       = (state == PEND);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q            <= '0;
            shadow       <= R'(DUTY_RST);
            bus.duty_act <= R'(DUTY_RST);
            bus.ack      <= '0;
            bus.pwm_out  <= 1'b0;
            last_grant   <= LW'(NREQ - 1);
            state        <= IDLE;
        end else begin
            q           <= bus.en ? q + 1'b1 : '0;
            bus.pwm_out <= bus.en && (q < bus.duty_act);
            bus.ack     <= (state == IDLE && any) ? gnt : '0;
            if (state == IDLE && any) begin
                shadow     <= bus.duty_in[win*R +: R];
                last_grant <= win;
                state      <= PEND;
            end else if (state == PEND && (!bus.en || bus.period_end)) begin
                // Swap on the wrap edge so the new duty owns the whole next period.
                bus.duty_act <= shadow;
                state        <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pwm_arbitro.sv
// tb_pwm_arbitro: scenario tasks plus randomized traffic against an integer cycle model of the PWM arbiter.
module tb_pwm_arbitro;
    import pwm_pkg::*;
    localparam int R = 6, NREQ = 3, P = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vec = 0, errs = 0;
    int dval[NREQ];
    int m_q = 0, m_duty = 0, m_shadow = 0, m_last = 0, m_ack = -1;
    bit m_pend = 0, m_pwm = 0;
    always #5 clk = ~clk;
    pwm_arbitro_if #(.R(R), .NREQ(NREQ)) bus();
    pwm_arbitro #(.R(R), .NREQ(NREQ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always_comb begin
        bus.duty_in = '0;
        for (int i = 0; i < NREQ; i++) bus.duty_in[i*R +: R] = R'(dval[i]);
    end
    wire [11:0] got = {bus.ack, bus.duty_act, bus.busy, bus.pwm_out, bus.period_end};

    // Advance one clock: the model consumes the inputs presented before the edge.
    task automatic tick();
        int w;
        @(posedge clk);
        if (!rst_n) begin
            m_q = 0; m_duty = P / 2; m_shadow = P / 2; m_last = NREQ - 1;
            m_ack = -1; m_pend = 0; m_pwm = 0;
        end else begin
            m_pwm = bus.en && (m_q < m_duty);
            m_ack = -1;
            if (m_pend) begin
                if (!bus.en || m_q == P - 1) begin m_duty = m_shadow; m_pend = 0; end
            end else if (bus.req != 0) begin
                w = m_last;
                do w = (w + 1) % NREQ; while (!bus.req[w]);
                m_shadow = dval[w]; m_ack = w; m_last = w; m_pend = 1;
            end
            m_q = bus.en ? (m_q + 1) % P : 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [11:0] expv();
        logic [NREQ-1:0] a;
        a = (m_ack < 0) ? '0 : NREQ'(1) << m_ack;
        return {a, R'(m_duty), m_pend, m_pwm, bus.en && (m_q == P - 1)};
    endfunction

    task automatic test_reset();
        rst_n = 0; bus.en = 0; bus.req = '0;
        for (int i = 0; i < NREQ; i++) dval[i] = 0;
        tick(); tick();
        vec++; if (got !== expv()) begin errs++; $display("FAIL reset_model got %h exp %h", got, expv()); end
        vec++; if (got !== {3'b000, 6'd32, 3'b000}) begin errs++; $display("FAIL reset_const got %h exp %h", got, {3'b000, 6'd32, 3'b000}); end
        rst_n = 1;
    endtask

    task automatic test_free_run();
        int hi = 0, pe = 0;
        bus.en = 1;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            vec++; if (got !== expv()) begin errs++; $display("FAIL free_run cyc %0d got %h exp %h", i, got, expv()); end
            hi += int'(bus.pwm_out); pe += int'(bus.period_end);
        end
        vec++; if (hi != P) begin errs++; $display("FAIL free_run_high got %0d exp %0d", hi, P); end
        vec++; if (pe != 2) begin errs++; $display("FAIL free_run_period_end got %0d exp 2", pe); end
    endtask

    task automatic test_single_grant();
        int hi = 0;
        for (int n = 0; m_q != 10; n++) begin
            if (n > 2 * P) begin errs++; vec++; $display("FAIL single_wait_timeout got q %0d exp 10", m_q); break; end
            tick();
        end
        bus.req = 3'b010; dval[1] = 48;
        tick();
        vec++; if (bus.ack !== 3'b010) begin errs++; $display("FAIL single_ack got %b exp 010", bus.ack); end
        bus.req = '0;
        for (int n = 0; m_pend; n++) begin
            if (n > 2 * P) begin errs++; vec++; $display("FAIL single_apply_timeout busy stuck exp idle"); break; end
            vec++; if (got !== expv()) begin errs++; $display("FAIL single_pend got %h exp %h", got, expv()); end
            tick();
        end
        vec++; if (bus.duty_act !== 6'd48 || m_q != 0) begin errs++; $display("FAIL single_apply got %0d q %0d exp 48 q 0", bus.duty_act, m_q); end
        for (int i = 0; i < P; i++) begin
            tick();
            hi += int'(bus.pwm_out);
        end
        vec++; if (hi != 48) begin errs++; $display("FAIL single_high got %0d exp 48", hi); end
    endtask

    task automatic test_rotation();
        int acks[$];
        int duties[$];
        logic [R-1:0] prev;
        rst_n = 0; tick(); rst_n = 1;
        dval[0] = 8; dval[1] = 16; dval[2] = 24;
        bus.req = 3'b111;
        prev = bus.duty_act;
        for (int i = 0; i < 4 * P; i++) begin
            tick();
            vec++; if (got !== expv()) begin errs++; $display("FAIL rotation cyc %0d got %h exp %h", i, got, expv()); end
            for (int k = 0; k < NREQ; k++) if (bus.ack[k]) acks.push_back(k);
            if (bus.duty_act !== prev) begin duties.push_back(int'(bus.duty_act)); prev = bus.duty_act; end
        end
        bus.req = '0;
        vec++; if (acks.size() != 4 || acks[0] != 0 || acks[1] != 1 || acks[2] != 2 || acks[3] != 0)
            begin errs++; $display("FAIL rotation_acks got %p exp 0 1 2 0", acks); end
        vec++; if (duties.size() < 3 || duties[0] != 8 || duties[1] != 16 || duties[2] != 24)
            begin errs++; $display("FAIL rotation_duties got %p exp 8 16 24", duties); end
    endtask

    task automatic test_coincide();
        int cnt = 0;
        for (int n = 0; m_pend || m_q != P - 1; n++) begin
            if (n > 3 * P) begin errs++; vec++; $display("FAIL coincide_wait_timeout q %0d exp 63 idle", m_q); break; end
            tick();
        end
        bus.req = 3'b001; dval[0] = 20;
        tick();
        bus.req = '0;
        while (bus.busy === 1'b1 && cnt < 2 * P) begin
            vec++; if (got !== expv()) begin errs++; $display("FAIL coincide_pend got %h exp %h", got, expv()); end
            cnt++;
            tick();
        end
        vec++; if (cnt != P) begin errs++; $display("FAIL coincide_busy_len got %0d exp %0d", cnt, P); end
        vec++; if (bus.duty_act !== 6'd20) begin errs++; $display("FAIL coincide_apply got %0d exp 20", bus.duty_act); end
    endtask

    task automatic test_boundary();
        int vals[2] = '{0, 63};
        foreach (vals[j]) begin
            int hi = 0;
            for (int n = 0; m_pend; n++) begin if (n > 2 * P) break; tick(); end
            bus.req = 3'b010; dval[1] = vals[j];
            tick();
            bus.req = '0;
            for (int n = 0; m_pend; n++) begin
                if (n > 2 * P) begin errs++; vec++; $display("FAIL boundary_timeout v %0d busy stuck", vals[j]); break; end
                tick();
            end
            for (int i = 0; i < P; i++) begin
                tick();
                vec++; if (got !== expv()) begin errs++; $display("FAIL boundary v %0d got %h exp %h", vals[j], got, expv()); end
                hi += int'(bus.pwm_out);
            end
            vec++; if (hi != vals[j]) begin errs++; $display("FAIL boundary_high got %0d exp %0d", hi, vals[j]); end
        end
        for (int n = 0; m_pend || m_q != 5; n++) begin
            if (n > 3 * P) begin errs++; vec++; $display("FAIL en_off_wait_timeout q %0d", m_q); break; end
            tick();
        end
        bus.req = 3'b100; dval[2] = 40;
        tick();
        bus.req = '0;
        tick();
        bus.en = 0;
        tick();
        vec++; if (got !== expv()) begin errs++; $display("FAIL en_off_model got %h exp %h", got, expv()); end
        vec++; if (bus.duty_act !== 6'd40 || bus.busy !== 1'b0 || bus.pwm_out !== 1'b0)
            begin errs++; $display("FAIL en_off_apply got duty %0d busy %b pwm %b exp 40 0 0", bus.duty_act, bus.busy, bus.pwm_out); end
        tick();
        vec++; if (bus.pwm_out !== 1'b0 || bus.period_end !== 1'b0) begin errs++; $display("FAIL en_off_hold got pwm %b pe %b exp 0 0", bus.pwm_out, bus.period_end); end
        bus.en = 1;
    endtask

    task automatic test_reset_pend();
        for (int n = 0; m_pend || m_q != 5; n++) begin
            if (n > 3 * P) begin errs++; vec++; $display("FAIL rst_pend_wait_timeout q %0d", m_q); break; end
            tick();
        end
        bus.req = 3'b100; dval[2] = 50;
        tick();
        bus.req = '0;
        vec++; if (bus.ack !== 3'b100 || bus.busy !== 1'b1) begin errs++; $display("FAIL rst_pend_grant got ack %b busy %b exp 100 1", bus.ack, bus.busy); end
        rst_n = 0;
        tick();
        vec++; if (got !== {3'b000, 6'd32, 3'b000}) begin errs++; $display("FAIL rst_pend_clear got %h exp %h", got, {3'b000, 6'd32, 3'b000}); end
        rst_n = 1;
        bus.req = 3'b001; dval[0] = 9;
        tick();
        bus.req = '0;
        vec++; if (bus.ack !== 3'b001 || got !== expv()) begin errs++; $display("FAIL rst_pend_regrant got %h exp %h", got, expv()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (bus.ack[k]) bus.req[k] = 1'b0;
                else if (!bus.req[k] && $urandom_range(0, 7) == 0) begin
                    bus.req[k] = 1'b1;
                    dval[k] = int'($urandom_range(0, P - 1));
                end
            end
            bus.en = ($urandom_range(0, 31) != 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
            vec++; if (got !== expv()) begin errs++; $display("FAIL random cyc %0d got %h exp %h", i, got, expv()); end
        end
        rst_n = 1; bus.en = 1; bus.req = '0;
    endtask

    initial begin
        bus.en = 0; bus.req = '0;
        test_reset();
        test_free_run();
        test_single_grant();
        test_rotation();
        test_coincide();
        test_boundary();
        test_reset_pend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
